// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Segment indices address the packed per-segment stall/flush vectors.
package pipe_hazard_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [1:0] WD_SEL_LOAD = 2'b10;

    localparam int NUM_SEG    = 4;
    localparam int SEG_IF_ID  = 0;
    localparam int SEG_ID_EX  = 1;
    localparam int SEG_EX_MEM = 2;
    localparam int SEG_MEM_WB = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait tracker: RUN/WAIT state, saturating wait counter, sticky timeout flag.
// Everything holds while i_en=0; reset returns to RUN asynchronously.
module mem_wait_fsm
    import pipe_hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_memhold,
    input  logic i_mem_ack,
    output logic o_mem_wait,
    output logic o_mem_err
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic                r_err;
    logic                w_err_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RUN;
            r_wcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        if (i_en) begin
            case (r_state)
                RUN: begin
                    if (i_memhold) begin
                        w_state_nxt = WAIT;
                        w_wcnt_nxt  = WCNT_ONE;
                    end
                end
                WAIT: begin
                    if (i_mem_ack) begin
                        w_state_nxt = RUN;
                        w_wcnt_nxt  = '0;
                    end else if (r_wcnt != WCNT_MAX) begin
                        w_wcnt_nxt = r_wcnt + WCNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_wcnt_nxt  = '0;
                end
            endcase
        end
        // Flag lands on the same edge the counter reaches the limit.
        w_err_nxt = r_err | (w_wcnt_nxt == WCNT_MAX);
    end

    assign o_mem_wait = (r_state == WAIT);
    assign o_mem_err  = r_err;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC hold and per-segment stall/flush from load-use,
// taken branch and memory wait; combinational controls plus event counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_global_en,
    input  logic [4:0]       i_id_rf_ra0,
    input  logic [4:0]       i_id_rf_ra1,
    input  logic             i_ex_rf_we,
    input  logic [4:0]       i_ex_rf_wa,
    input  logic [1:0]       i_ex_rf_wd_sel,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_stall,
    output logic             o_ex_mem_flush,
    output logic             o_mem_wb_stall,
    output logic             o_mem_wb_flush,
    output logic             o_mem_wait,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic               w_memhold;
    logic               w_loaduse;
    logic               w_pc_stall;
    logic [NUM_SEG-1:0] w_stall;
    logic [NUM_SEG-1:0] w_flush;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    assign w_memhold = i_mem_req & ~i_mem_ack;
    assign w_loaduse = i_ex_rf_we & (i_ex_rf_wd_sel == WD_SEL_LOAD) & (i_ex_rf_wa != 5'd0)
                     & ((i_ex_rf_wa == i_id_rf_ra0) | (i_ex_rf_wa == i_id_rf_ra1));

    // A branch or load-use hidden behind memhold is re-evaluated once memhold drops.
    always_comb begin
        w_pc_stall = 1'b0;
        w_stall    = '0;
        w_flush    = '0;
        if (i_rst) begin
            w_flush = '1;
        end else if (!i_global_en) begin
            w_pc_stall = 1'b1;
            w_stall    = '1;
        end else if (w_memhold) begin
            w_pc_stall            = 1'b1;
            w_stall[SEG_IF_ID]    = 1'b1;
            w_stall[SEG_ID_EX]    = 1'b1;
            w_stall[SEG_EX_MEM]   = 1'b1;
            w_flush[SEG_MEM_WB]   = 1'b1;
        end else if (i_ex_br_taken) begin
            w_flush[SEG_IF_ID]    = 1'b1;
            w_flush[SEG_ID_EX]    = 1'b1;
        end else if (w_loaduse) begin
            w_pc_stall            = 1'b1;
            w_stall[SEG_IF_ID]    = 1'b1;
            w_flush[SEG_ID_EX]    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_global_en) begin
            if (w_pc_stall) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (i_ex_br_taken && !w_memhold) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_global_en),
        .i_memhold  (w_memhold),
        .i_mem_ack  (i_mem_ack),
        .o_mem_wait (o_mem_wait),
        .o_mem_err  (o_mem_err)
    );

    assign o_pc_stall     = w_pc_stall;
    assign o_if_id_stall  = w_stall[SEG_IF_ID];
    assign o_if_id_flush  = w_flush[SEG_IF_ID];
    assign o_id_ex_stall  = w_stall[SEG_ID_EX];
    assign o_id_ex_flush  = w_flush[SEG_ID_EX];
    assign o_ex_mem_stall = w_stall[SEG_EX_MEM];
    assign o_ex_mem_flush = w_flush[SEG_EX_MEM];
    assign o_mem_wb_stall = w_stall[SEG_MEM_WB];
    assign o_mem_wb_flush = w_flush[SEG_MEM_WB];
    assign o_stall_cnt    = r_stall_cnt;
    assign o_flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    // {pc, if_id s/f, id_ex s/f, ex_mem s/f, mem_wb s/f}
    localparam logic [8:0] CTL_NONE = 9'b0_00_00_00_00;
    localparam logic [8:0] CTL_RST  = 9'b0_01_01_01_01;
    localparam logic [8:0] CTL_FRZ  = 9'b1_10_10_10_10;
    localparam logic [8:0] CTL_MEM  = 9'b1_10_10_10_01;
    localparam logic [8:0] CTL_BR   = 9'b0_01_01_00_00;
    localparam logic [8:0] CTL_LU   = 9'b1_10_01_00_00;

    logic             clk = 1'b0;
    logic             rst;
    logic             global_en;
    logic [4:0]       id_rf_ra0, id_rf_ra1, ex_rf_wa;
    logic             ex_rf_we;
    logic [1:0]       ex_rf_wd_sel;
    logic             ex_br_taken, mem_req, mem_ack;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic             ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
    logic             mem_wait, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       ctl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                  ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_global_en    (global_en),
        .i_id_rf_ra0    (id_rf_ra0),
        .i_id_rf_ra1    (id_rf_ra1),
        .i_ex_rf_we     (ex_rf_we),
        .i_ex_rf_wa     (ex_rf_wa),
        .i_ex_rf_wd_sel (ex_rf_wd_sel),
        .i_ex_br_taken  (ex_br_taken),
        .i_mem_req      (mem_req),
        .i_mem_ack      (mem_ack),
        .o_pc_stall     (pc_stall),
        .o_if_id_stall  (if_id_stall),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_stall  (id_ex_stall),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_stall (ex_mem_stall),
        .o_ex_mem_flush (ex_mem_flush),
        .o_mem_wb_stall (mem_wb_stall),
        .o_mem_wb_flush (mem_wb_flush),
        .o_mem_wait     (mem_wait),
        .o_mem_err      (mem_err),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one vector on the falling edge and let combinational outputs settle.
    task automatic apply(input logic en, input logic we, input logic [1:0] sel,
                         input logic [4:0] wa, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic br, input logic req, input logic ack);
        @(negedge clk);
        global_en    = en;
        ex_rf_we     = we;
        ex_rf_wd_sel = sel;
        ex_rf_wa     = wa;
        id_rf_ra0    = ra0;
        id_rf_ra1    = ra1;
        ex_br_taken  = br;
        mem_req      = req;
        mem_ack      = ack;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        global_en = 1'b1; ex_rf_we = 1'b0; ex_rf_wd_sel = 2'b00; ex_rf_wa = 5'd0;
        id_rf_ra0 = 5'd0; id_rf_ra1 = 5'd0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

        // Reset
        apply(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        check_eq("rst_ctl", 32'(ctl), 32'(CTL_RST));
        check_eq("rst_stall_cnt", stall_cnt, 0);
        check_eq("rst_flush_cnt", flush_cnt, 0);
        check_eq("rst_wait_err", {mem_wait, mem_err}, 0);
        @(negedge clk); rst = 1'b0; #1;
        check_eq("idle_ctl", 32'(ctl), 32'(CTL_NONE));

        // Load-use on ra1, then retire
        apply(1, 1, 2'b10, 5, 0, 5, 0, 0, 0);
        check_eq("lu_ctl", 32'(ctl), 32'(CTL_LU));
        apply(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        check_eq("lu_done_ctl", 32'(ctl), 32'(CTL_NONE));
        check_eq("lu_stall_cnt", stall_cnt, 1);
        // x0 destination never interlocks; non-load writeback never interlocks
        apply(1, 1, 2'b10, 0, 0, 5, 0, 0, 0);
        check_eq("lu_x0_ctl", 32'(ctl), 32'(CTL_NONE));
        apply(1, 1, 2'b01, 5, 5, 5, 0, 0, 0);
        check_eq("lu_alu_ctl", 32'(ctl), 32'(CTL_NONE));

        // Branch overrides load-use
        apply(1, 1, 2'b10, 5, 0, 5, 1, 0, 0);
        check_eq("br_lu_ctl", 32'(ctl), 32'(CTL_BR));
        check_eq("br_flush_cnt_pre", flush_cnt, 0);
        apply(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        check_eq("br_flush_cnt", flush_cnt, 1);
        check_eq("br_stall_cnt", stall_cnt, 1);

        // Three-cycle memory wait, with a branch deferred behind it
        apply(1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        check_eq("mw1_ctl", 32'(ctl), 32'(CTL_MEM));
        check_eq("mw1_wait", mem_wait, 0);
        apply(1, 0, 2'b00, 0, 0, 0, 1, 1, 0);
        check_eq("mw2_ctl", 32'(ctl), 32'(CTL_MEM));
        check_eq("mw2_wait", mem_wait, 1);
        apply(1, 0, 2'b00, 0, 0, 0, 1, 1, 0);
        check_eq("mw3_ctl", 32'(ctl), 32'(CTL_MEM));
        check_eq("mw3_wait", mem_wait, 1);
        check_eq("mw3_flush_cnt", flush_cnt, 1);
        apply(1, 0, 2'b00, 0, 0, 0, 1, 1, 1);
        check_eq("mw_ack_ctl", 32'(ctl), 32'(CTL_BR));
        check_eq("mw_ack_wait", mem_wait, 1);
        apply(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        check_eq("mw_done_wait", mem_wait, 0);
        check_eq("mw_stall_cnt", stall_cnt, 4);
        check_eq("mw_flush_cnt", flush_cnt, 2);
        check_eq("mw_no_err", mem_err, 0);

        // Freeze during WAIT and during a branch, then run into timeout
        apply(1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        check_eq("frz_wait_ctl", 32'(ctl), 32'(CTL_FRZ));
        check_eq("frz_wait_state", mem_wait, 1);
        check_eq("frz_stall_cnt", stall_cnt, 5);
        apply(0, 0, 2'b00, 0, 0, 0, 1, 1, 0);
        check_eq("frz_br_ctl", 32'(ctl), 32'(CTL_FRZ));
        apply(1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        check_eq("frz_cnts", {stall_cnt[15:0], flush_cnt[15:0]}, {16'd5, 16'd2});
        check_eq("frz_still_wait", mem_wait, 1);
        apply(1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        check_eq("to_pre_err", mem_err, 0);
        apply(1, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        check_eq("to_err", mem_err, 1);
        check_eq("to_ack_ctl", 32'(ctl), 32'(CTL_NONE));
        check_eq("to_stall_cnt", stall_cnt, 8);
        apply(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        check_eq("to_err_sticky", mem_err, 1);
        check_eq("to_run", mem_wait, 0);

        // Asynchronous reset in the middle of WAIT
        apply(1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        check_eq("arst_pre_wait", mem_wait, 1);
        rst = 1'b1; #1;
        check_eq("arst_wait", mem_wait, 0);
        check_eq("arst_err", mem_err, 0);
        check_eq("arst_ctl", 32'(ctl), 32'(CTL_RST));
        check_eq("arst_cnts", stall_cnt | flush_cnt, 0);
        @(negedge clk); rst = 1'b0;
        apply(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        check_eq("post_arst_ctl", 32'(ctl), 32'(CTL_NONE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control-side counterpart of the pipeline segment registers; generates the stall/flush controls they consume.
- Produces the PC hold plus stall/flush for the four segments IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sources: load-use interlock, taken-branch redirect, and a multi-cycle data-memory req/ack wait.
- Keeps a small wait-state machine, a memory timeout watchdog and free-running performance counters.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles per memory request before mem_err is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- global_en  in  1  pipeline enable; 0 freezes everything.
- id_rf_ra0  in  5  ID-stage source register 0.
- id_rf_ra1  in  5  ID-stage source register 1.
- ex_rf_we  in  1  EX-stage instruction writes the register file.
- ex_rf_wa  in  5  EX-stage destination register.
- ex_rf_wd_sel  in  2  EX-stage writeback select; 2'b10 = load data.
- ex_br_taken  in  1  EX-stage branch/jump resolved taken.
- mem_req  in  1  MEM-stage data-memory request pending.
- mem_ack  in  1  data memory completes the request this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall, if_id_flush  out  1 each  IF/ID segment controls.
- id_ex_stall, id_ex_flush  out  1 each  ID/EX segment controls.
- ex_mem_stall, ex_mem_flush  out  1 each  EX/MEM segment controls.
- mem_wb_stall, mem_wb_flush  out  1 each  MEM/WB segment controls.
- mem_wait  out  1  FSM is in WAIT.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_stall=1 and global_en=1.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Stall/flush outputs are combinational from inputs and state, so segment registers act at the same edge.
- Reset:
  - While rst=1, all *_stall=0 and all *_flush=1.
  - State goes to RUN; mem_err, the wait counter, stall_cnt and flush_cnt go to 0.
- Sources:
  - memhold = mem_req & ~mem_ack.
  - loaduse = ex_rf_we & (ex_rf_wd_sel==2'b10) & (ex_rf_wa!=0) & (ex_rf_wa==id_rf_ra0 | ex_rf_wa==id_rf_ra1).
- Priority, highest first:
  1. global_en=0: every stall=1, every flush=0; state, counters and the wait counter hold.
  2. memhold: pc/if_id/id_ex/ex_mem stall=1; mem_wb_flush=1 (bubble into WB); all other controls 0. A pending branch or load-use is deferred, not dropped.
  3. ex_br_taken: if_id_flush=1 and id_ex_flush=1; no stalls. Overrides load-use, because the ID instruction is being discarded.
  4. loaduse: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble per occurrence).
  5. Otherwise all controls 0.
- Never assert stall and flush on the same segment together.
- FSM states are RUN and WAIT:
  - RUN -> WAIT when global_en & memhold; the wait counter is set to 1.
  - WAIT -> WAIT while mem_ack=0; the wait counter increments, saturating at MEM_TIMEOUT.
  - WAIT -> RUN on mem_ack=1; stalls release that same cycle and the counter clears.
  - mem_ack in the same cycle as mem_req while in RUN means zero wait and no state change.
  - mem_wait = (state==WAIT).
- Timeout:
  - When the wait counter reaches MEM_TIMEOUT, mem_err is set.
  - mem_err is sticky until rst; it does not release the stall.
- Counters:
  - stall_cnt increments on every cycle with global_en & pc_stall.
  - flush_cnt increments on every cycle with global_en & ex_br_taken & ~memhold.
  - Both wrap modulo 2^CNT_W.
- Reset asserted mid-WAIT forces RUN immediately, asynchronously.

Decomposition:
- Package pipe_hazard_pkg holds:
  - state enum {RUN, WAIT};
  - WD_SEL_LOAD = 2'b10;
  - segment index constants.
- Sub-module mem_wait_fsm holds the state, wait counter and mem_err. The top level keeps the priority logic and counters.

Test Plan:
- Reset: hold rst=1 -> all flush=1, all stall=0, stall_cnt=0. Release -> all controls 0.
- Load-use: ex_rf_we=1, wd_sel=2'b10, ex_rf_wa=5, id_rf_ra1=5 -> pc_stall=if_id_stall=id_ex_flush=1 for one cycle. Same stimulus with wa=0 -> no stall.
- Branch plus load-use together: ex_br_taken=1 with the load-use condition -> if_id_flush=id_ex_flush=1, pc_stall=0, flush_cnt goes 0->1.
- Memory wait: mem_req=1 with mem_ack low for 3 cycles, then high -> mem_wait=1 for 3 cycles, front stalls plus mem_wb_flush for 3 cycles, released in the ack cycle, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4 with mem_ack never asserted -> mem_err=1 after the 4th wait cycle and stays 1 after the later ack. A mid-WAIT rst returns to RUN and clears mem_err.
- global_en=0 during WAIT and during a branch -> all stalls=1, counters frozen, state unchanged.
